// File: rtl/pb_sweep_ctrl.sv
// Push-button sweep sequencer: walks a one-hot position 0..15 on a divided hz100 tick.
// Latency: a button edge takes effect at the 2nd hz100 edge after it is first sampled; outputs are registered decodes.
// Backpressure: none; each rising button level is one event, and holding or releasing a button does nothing more.
//
// Ports:
//   hz100      - 100 Hz board clock, all state updates on its rising edge
//   reset      - asynchronous active-low reset (IDLE, pos=0, dir=up)
//   btn_start  - raw button: start from IDLE / resume from HOLD
//   btn_stop   - raw button: RUN -> HOLD, HOLD -> IDLE (pos kept)
//   btn_dir    - raw button: toggle sweep direction
//   btn_clear  - raw button: back to IDLE, pos=0, dir=up
//   level      - one-hot position to the bargraph (bit[pos] set)
//   sel        - pos[2:0] to the 3-to-8 decimal-point decoder
//   running    - high while sweeping
//   dir        - 1 = increasing pos, 0 = decreasing
//
// Build option: define WRAP_MODE_EN to wrap 15<->0 instead of bouncing at the ends.

module pb_sweep_ctrl #(
  parameter int TICK_DIV = 25
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_stop,
  input  logic        btn_dir,
  input  logic        btn_clear,
  output logic [15:0] level,
  output logic [2:0]  sel,
  output logic        running,
  output logic        dir
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    pos, pos_nx;
  logic          dir_nx;
  logic          dir_t;
  logic [CW-1:0] cnt, cnt_nx;

  // Button vector order: {clear, dir, stop, start}
  logic [3:0] btn_raw;
  logic [3:0] sync1, sync2, sync3;
  logic [3:0] ev;
  logic       ev_start, ev_stop, ev_dir, ev_clear;

  assign btn_raw = {btn_clear, btn_dir, btn_stop, btn_start};

  // Two flops for metastability, third flop to find the rising edge.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign ev       = sync2 & ~sync3;
  assign ev_start = ev[0];
  assign ev_stop  = ev[1];
  assign ev_dir   = ev[2];
  assign ev_clear = ev[3];

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pos   <= '0;
      dir   <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      pos   <= pos_nx;
      dir   <= dir_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pos_nx   = pos;
    dir_nx   = dir;
    cnt_nx   = cnt;
    // A direction event lands before any step in the same cycle, so the
    // step moves the new way and the end-of-range rule sees the new dir.
    dir_t    = dir ^ ev_dir;

    if (ev_clear) begin
      state_nx = IDLE;
      pos_nx   = '0;
      dir_nx   = 1'b1;
      cnt_nx   = '0;
    end else begin
      dir_nx = dir_t;
      case (state)
        IDLE: begin
          if (ev_start && !ev_stop) begin
            state_nx = RUN;
            cnt_nx   = '0;
          end
        end
        RUN: begin
          if (ev_stop) begin
            // Stop beats a coincident step: cnt stays where it is.
            state_nx = HOLD;
          end else if (cnt == CNT_LAST) begin
            cnt_nx = '0;
`ifdef WRAP_MODE_EN
            pos_nx = dir_t ? pos + 4'd1 : pos - 4'd1;
`else
            if (dir_t) begin
              if (pos == 4'd15) begin
                pos_nx = 4'd14;
                dir_nx = 1'b0;
              end else begin
                pos_nx = pos + 4'd1;
              end
            end else begin
              if (pos == 4'd0) begin
                pos_nx = 4'd1;
                dir_nx = 1'b1;
              end else begin
                pos_nx = pos - 4'd1;
              end
            end
`endif
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        HOLD: begin
          if (ev_stop) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (ev_start) begin
            state_nx = RUN;
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  assign level   = 16'd1 << pos;
  assign sel     = pos[2:0];
  assign running = (state == RUN);

endmodule

// File: doc/pb_sweep_ctrl.md
Name: pb_sweep_ctrl

Overview:
- Sequencer for the lab display datapath, driven by debounced-free push buttons.
- Moves a position pointer 0..15 across the display on a divided hz100 tick.
- Drives a one-hot 16-bit level into the bargraph block and a 3-bit select into the 3-to-8 decoder, which lights one decimal point.
- Provides start/stop/hold, direction reversal and clear.

Parameters:
TICK_DIV, 25, hz100 cycles per position step (minimum 2); 25 gives 4 steps/s.

Ports:
hz100      input   1   clock, 100 Hz board clock
reset      input   1   asynchronous, active-low reset
btn_start  input   1   raw push-button level: start/resume
btn_stop   input   1   raw push-button level: hold / stop
btn_dir    input   1   raw push-button level: reverse direction
btn_clear  input   1   raw push-button level: clear to idle
level      output  16  one-hot position, bit[pos]=1; feeds bargraph input
sel        output  3   pos[2:0]; feeds 3-to-8 decoder input
running    output  1   1 while in RUN
dir        output  1   1 = up (increasing pos), 0 = down

Behaviour:
- Clocking and reset:
  - All state updates on the hz100 rising edge.
  - reset low asynchronously forces: state=IDLE, pos=0, dir=1, cnt=0, all sync/edge flops=0.
  - Resulting outputs: level=16'h0001, sel=0, running=0, dir=1.
  - Reset asserted mid-sweep takes effect immediately, regardless of the clock.
- Input conditioning:
  - Each btn_* passes through a 2-flop synchronizer plus a third flop for edge detection.
  - An event is a rising edge of the synchronized signal.
  - A button that rises before edge k produces its effect in the registers at edge k+2, visible after edge k+2.
  - Held buttons generate exactly one event.
  - Releasing a button generates nothing.
- State machine (IDLE, RUN, HOLD):
  - IDLE: start -> RUN with cnt=0.
  - RUN: stop -> HOLD, with cnt and pos frozen.
  - HOLD: start -> RUN, cnt resumes from its frozen value; stop -> IDLE, pos is kept.
  - Any state: clear -> IDLE, pos=0, dir=1, cnt=0.
- Event priority in the same cycle: clear > stop > start. dir is independent of the state events but is ignored when clear fires.
- dir event: toggles dir in every state.
- Divider and stepping:
  - cnt counts only in RUN, from 0 to TICK_DIV-1 then back to 0.
  - The cycle with cnt==TICK_DIV-1 is a step cycle.
  - The first step occurs TICK_DIV cycles after entering RUN from IDLE.
- Step rule (bounce):
  - dir=1: pos<15 -> pos+1; pos==15 -> pos=14, dir=0.
  - dir=0: pos>0 -> pos-1; pos==0 -> pos=1, dir=1.
- Step coinciding with a dir event: the toggled direction is used for that step, then the bounce rule applies to the new direction.
- Step coinciding with stop: stop wins; no step, and cnt freezes at TICK_DIV-1.
- Outputs:
  - Outputs are pure decodes of registers; no combinational path from btn_*.
  - level = 1<<pos, so exactly one bit is ever set.
  - sel = pos[2:0], so pos 8..15 alias sel 0..7.
  - running = (state==RUN).
  - dir is the register itself.
- Widths: pos is 4 bits; cnt is clog2(TICK_DIV) bits.

Optional Feature:
WRAP_MODE_EN
- Defined: wrap instead of bounce.
  - Going up: pos 15 -> 0.
  - Going down: pos 0 -> 15.
  - dir changes only on btn_dir events.
- Undefined: bounce rule above.
- All other behaviour is identical in both builds.

Test Plan:
All scenarios use TICK_DIV=4.
1. Release reset, no buttons for 20 cycles -> level=0x0001, sel=0, running=0, dir=1 throughout.
2. Pulse btn_start for 3 cycles -> running=1 two edges after the rise; level steps 0x0001, 0x0002, 0x0004 every 4 cycles; sel=0,1,2.
3. Run to pos=15 -> next step gives level=0x4000, dir=0. Run down to pos=0 -> next step gives pos=1, dir=1. With WRAP_MODE_EN: 15 -> level=0x0001, dir stays 1.
4. Mid-run btn_stop -> running=0, level frozen for 50 cycles. btn_start -> resumes; the first step occurs after the remaining cnt cycles, not 4. Second btn_stop from HOLD -> IDLE with pos kept.
5. btn_start, btn_stop and btn_clear rising on the same cycle while in RUN at pos=9 -> IDLE, level=0x0001, dir=1. btn_dir coincident with a step at pos=5, dir=1 -> pos=4, dir=0.
6. Assert reset (low) mid-sweep between clock edges -> outputs return to reset values before the next hz100 edge; no step on the first edge after release.
